// File: rtl/axis_pkt_rr_arbiter_pkg.sv
// Shared types, limits and parameter checks for the packet round-robin stream arbiter family.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arbState_e;

  localparam int MAX_PORTS = 8;

  // Port count must fit the supported range and be addressable by the grant index.
  function automatic bit arbParamsLegal(int numPorts, int idWidth);
    return (numPorts >= 2) && (numPorts <= MAX_PORTS) && ((1 << idWidth) >= numPorts);
  endfunction

endpackage

// File: rtl/axis_pkt_rr_arbiter_if.sv
// AXI-Stream bundle; NUM_LANES > 1 packs several parallel streams (lane i data at [i*DATA_WIDTH +: DATA_WIDTH]).
interface axis_pkt_rr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 1
);

  logic [NUM_LANES*DATA_WIDTH-1:0] tdata;
  logic [NUM_LANES-1:0]            tvalid;
  logic [NUM_LANES-1:0]            tready;
  logic [NUM_LANES-1:0]            tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_pkt_rr_arbiter_pick.sv
// Combinational round-robin picker: first requester scanning last_grant+1, last_grant+2, ... mod NUM_PORTS.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ID_WIDTH  = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  last_grant,
  output logic [ID_WIDTH-1:0]  gnt_idx,
  output logic                 gnt_valid
);

  if (!arbParamsLegal(NUM_PORTS, ID_WIDTH)) begin : g_bad_params
    $error("axis_rr_pick: NUM_PORTS must be 2..8 and fit in ID_WIDTH bits");
  end

  // Outer loop walks rotation distance; the first hit blocks all later ones.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!gnt_valid && req[p] && (p == ((int'(last_grant) + k) % NUM_PORTS))) begin
          gnt_idx   = ID_WIDTH'(p);
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-locked round-robin arbiter muxing NUM_PORTS AXI-Stream slaves onto one registered master.
// Define AXIS_ARB_TID_EN to add m_axis_tid, the source port index registered alongside each beat.
module axis_pkt_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2,
  parameter int ID_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  axis_pkt_rr_arbiter_if.slave  s_axis,
  axis_pkt_rr_arbiter_if.master m_axis,
  output logic [ID_WIDTH-1:0]   grant_idx,
  output logic                  busy
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [ID_WIDTH-1:0]   m_axis_tid
`endif
);

  arbState_e             state_q;
  logic [ID_WIDTH-1:0]   grantIdx_q;
  logic [ID_WIDTH-1:0]   lastGrant_q;
  logic                  outValid_q;
  logic                  outLast_q;
  logic [DATA_WIDTH-1:0] outData_q;
`ifdef AXIS_ARB_TID_EN
  logic [ID_WIDTH-1:0]   outTid_q;
`endif

  logic [ID_WIDTH-1:0]   pickIdx;
  logic                  pickValid;
  logic                  outReady;
  logic                  selValid;
  logic                  selLast;
  logic [DATA_WIDTH-1:0] selData;
  logic [NUM_PORTS-1:0]  sReady;
  logic                  xfer;

  axis_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_pick (
    .req        (s_axis.tvalid),
    .last_grant (lastGrant_q),
    .gnt_idx    (pickIdx),
    .gnt_valid  (pickValid)
  );

  // Mux the granted lane; only that lane sees ready, and only while locked.
  always_comb begin
    selValid = 1'b0;
    selLast  = 1'b0;
    selData  = '0;
    sReady   = '0;
    outReady = !outValid_q || m_axis.tready;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grantIdx_q == ID_WIDTH'(p)) begin
        selValid  = s_axis.tvalid[p];
        selLast   = s_axis.tlast[p];
        selData   = s_axis.tdata[p*DATA_WIDTH +: DATA_WIDTH];
        sReady[p] = (state_q == ARB_LOCKED) && outReady;
      end
    end
    xfer = (state_q == ARB_LOCKED) && outReady && selValid;
  end

  // Arbitration FSM plus output register; the lock is released only by a transferred tlast beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      grantIdx_q  <= '0;
      lastGrant_q <= ID_WIDTH'(NUM_PORTS - 1);
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outLast_q   <= 1'b0;
`ifdef AXIS_ARB_TID_EN
      outTid_q    <= '0;
`endif
    end else begin
      if (xfer) begin
        outValid_q <= 1'b1;
        outData_q  <= selData;
        outLast_q  <= selLast;
`ifdef AXIS_ARB_TID_EN
        outTid_q   <= grantIdx_q;
`endif
      end else if (outReady) begin
        outValid_q <= 1'b0;
      end

      case (state_q)
        ARB_IDLE: begin
          if (pickValid) begin
            grantIdx_q <= pickIdx;
            state_q    <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (xfer && selLast) begin
            lastGrant_q <= grantIdx_q;
            state_q     <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  assign s_axis.tready = sReady;
  assign m_axis.tvalid = outValid_q;
  assign m_axis.tdata  = outData_q;
  assign m_axis.tlast  = outLast_q;
  assign grant_idx     = grantIdx_q;
  assign busy          = (state_q == ARB_LOCKED);
`ifdef AXIS_ARB_TID_EN
  assign m_axis_tid    = outTid_q;
`endif

endmodule
